// File: rtl/kgp_instr_encoder_loader.sv
// kgp_instr_encoder_loader: packs symbolic KGP RISC instructions into 32-bit words and streams them into instruction memory.
// Optional KGP_ENC_CHECKSUM_EN adds an XOR checksum output over all words written in a session.
module kgp_instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mn,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_label,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_full
`ifdef KGP_ENC_CHECKSUM_EN
  , output logic [31:0]     checksum
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic [31:0] wdata_q, wdata_d, enc;
  logic [5:0] op;
  logic we_q, we_d, done_q, done_d, ill_q, ill_d, full_q, full_d;
  logic legal, accept, enter, room;
  assign legal = in_mn <= 5'd22;
  assign op    = {1'b0, in_mn - 5'd8};
  always_comb begin
    enc = '0;
    if (in_mn <= 5'd10) begin
      enc[31:26] = in_mn <= 5'd2 ? 6'd0 : in_mn <= 5'd4 ? 6'd1 : 6'd2;
      enc[25:21] = in_rs;
      enc[20:16] = in_rt;
      enc[15:11] = in_shamt;
      enc[4:0]   = in_mn <= 5'd2 ? in_mn : in_mn <= 5'd4 ? in_mn - 5'd3 : in_mn - 5'd5;
    end else if (in_mn <= 5'd14)
      enc = {op, in_rs, in_mn <= 5'd12 ? 5'd0 : in_rt, in_imm};
    else if (in_mn <= 5'd17)
      enc = {op, in_rs, in_label[20:0]};
    else if (in_mn == 5'd18)
      enc = {op, in_rs, 21'd0};
    else if (legal)
      enc = {op, in_label};
  end
  // a write still in flight already owns a slot, so it counts against DEPTH
  assign room     = (wc_q + (ADDR_W+1)'(we_q)) < DEPTH_C;
  assign in_ready = state_q == LOAD && room;
  assign accept   = in_valid && in_ready;
  assign enter    = start && state_q != LOAD;
  always_comb begin
    state_d = enter ? LOAD : (accept && in_last) ? DONE : state_q;
    we_d    = accept && legal;
    ptr_d   = enter ? BASE_C : ptr_q + ADDR_W'(we_d);
    addr_d  = we_d ? ptr_q : addr_q;
    wdata_d = we_d ? enc : wdata_q;
    wc_d    = enter ? '0 : wc_q + (ADDR_W+1)'(we_q);
    ill_d   = !enter && (ill_q || (accept && !legal));
    full_d  = !enter && (full_q || (state_q == LOAD && in_valid && !room));
    done_d  = state_q == DONE && !start;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wc_q    <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wc_q    <= wc_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      full_q  <= full_d;
    end
  end
`ifdef KGP_ENC_CHECKSUM_EN
  logic [31:0] cs_q, cs_d;
  assign cs_d = enter ? '0 : we_q ? cs_q ^ wdata_q : cs_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cs_q <= '0;
    else cs_q <= cs_d;
  end
  assign checksum = cs_q;
`endif
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign busy        = state_q == LOAD;
  assign done        = done_q;
  assign word_count  = wc_q;
  assign err_illegal = ill_q;
  assign err_full    = full_q;
endmodule

// File: tb/tb_kgp_instr_encoder_loader.sv
// tb_kgp_instr_encoder_loader: directed encoding table plus streaming, illegal, full and reset-abort sequences.
module tb_kgp_instr_encoder_loader;
  localparam int AW = 4;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_last = 0;
  logic [4:0] in_mn = 0, in_rs = 0, in_rt = 0, in_shamt = 0;
  logic [15:0] in_imm = 0;
  logic [25:0] in_label = 0;
  logic in_ready, imem_we, busy, done, err_illegal, err_full;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] word_count;
`ifdef KGP_ENC_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  int n_chk = 0, n_fail = 0;

  kgp_instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mn(in_mn), .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_label(in_label), .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .word_count(word_count),
    .err_illegal(err_illegal), .err_full(err_full)
`ifdef KGP_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] mn, rs, rt, sh;
    logic [15:0] imm;
    logic [25:0] lab;
    logic [31:0] exp;
    bit ill;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] mn, rs, rt, sh, input logic [15:0] imm, input logic [25:0] lab, input logic last);
    in_valid = 1; in_mn = mn; in_rs = rs; in_rt = rt; in_shamt = sh;
    in_imm = imm; in_label = lab; in_last = last;
  endtask

  task automatic idle_in;
    in_valid = 0; in_last = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, imem_we, 0);
    chk({tag, "_addr"}, imem_addr, 0);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wc"}, word_count, 0);
    chk({tag, "_ill"}, err_illegal, 0);
    chk({tag, "_full"}, err_full, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  logic [31:0] s2 [4];
  logic [31:0] cs_exp;

  initial begin
    tbl[0]  = '{5'd0,  5'd1,  5'd2,  5'd0,  16'h0000, 26'h0000000, 32'h00220000, 0};
    tbl[1]  = '{5'd1,  5'd5,  5'd6,  5'd0,  16'h0000, 26'h0000000, 32'h00A60001, 0};
    tbl[2]  = '{5'd2,  5'd31, 5'd31, 5'd31, 16'h0000, 26'h0000000, 32'h03FFF802, 0};
    tbl[3]  = '{5'd3,  5'd1,  5'd1,  5'd0,  16'h0000, 26'h0000000, 32'h04210000, 0};
    tbl[4]  = '{5'd4,  5'd0,  5'd0,  5'd3,  16'hFFFF, 26'h3FFFFFF, 32'h04001801, 0};
    tbl[5]  = '{5'd5,  5'd2,  5'd0,  5'd1,  16'h0000, 26'h0000000, 32'h08400800, 0};
    tbl[6]  = '{5'd10, 5'd7,  5'd8,  5'd0,  16'h0000, 26'h0000000, 32'h08E80005, 0};
    tbl[7]  = '{5'd11, 5'd3,  5'd9,  5'd7,  16'h0010, 26'h0000000, 32'h0C600010, 0};
    tbl[8]  = '{5'd12, 5'd1,  5'd5,  5'd0,  16'hFFFF, 26'h0000000, 32'h1020FFFF, 0};
    tbl[9]  = '{5'd13, 5'd2,  5'd3,  5'd0,  16'h1234, 26'h0000000, 32'h14431234, 0};
    tbl[10] = '{5'd14, 5'd31, 5'd31, 5'd31, 16'h8000, 26'h0000000, 32'h1BFF8000, 0};
    tbl[11] = '{5'd15, 5'd4,  5'd9,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h1C9FFFFF, 0};
    tbl[12] = '{5'd16, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h00ABCDE, 32'h200ABCDE, 0};
    tbl[13] = '{5'd17, 5'd1,  5'd0,  5'd0,  16'h0000, 26'h2000001, 32'h24200001, 0};
    tbl[14] = '{5'd18, 5'd5,  5'd3,  5'd0,  16'hFFFF, 26'h3FFFFFF, 32'h28A00000, 0};
    tbl[15] = '{5'd19, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000100, 32'h2C000100, 0};
    tbl[16] = '{5'd20, 5'd7,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h33FFFFFF, 0};
    tbl[17] = '{5'd21, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h1234567, 32'h35234567, 0};
    tbl[18] = '{5'd22, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000000, 32'h38000000, 0};
    tbl[19] = '{5'd23, 5'd1,  5'd2,  5'd3,  16'h0001, 26'h0000001, 32'h00000000, 1};
    tbl[20] = '{5'd31, 5'd1,  5'd2,  5'd3,  16'h0001, 26'h0000001, 32'h00000000, 1};
    s2 = '{32'h0C600010, 32'h08801004, 32'h00A60001, 32'h2C000100};

    step; step;
    chk_zero("reset");
    rst_n = 1;

    foreach (tbl[i]) begin
      start = 1; step; start = 0;
      chk($sformatf("v%0d_busy", i), busy, 1);
      beat(tbl[i].mn, tbl[i].rs, tbl[i].rt, tbl[i].sh, tbl[i].imm, tbl[i].lab, 1);
      chk($sformatf("v%0d_ready", i), in_ready, 1);
      step; idle_in;
      chk($sformatf("v%0d_we", i), imem_we, tbl[i].ill ? 0 : 1);
      if (!tbl[i].ill) begin
        chk($sformatf("v%0d_addr", i), imem_addr, 0);
        chk($sformatf("v%0d_wdata", i), imem_wdata, tbl[i].exp);
      end
      chk($sformatf("v%0d_ill", i), err_illegal, tbl[i].ill);
      step;
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_wc", i), word_count, tbl[i].ill ? 0 : 1);
    end

    start = 1; step; start = 0;
    chk("s2_done_clr", done, 0);
    chk("s2_ill_clr", err_illegal, 0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: beat(5'd11, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0, 0);
        1: beat(5'd9,  5'd4, 5'd0, 5'd2, 16'h0000, 26'h0, 0);
        2: beat(5'd1,  5'd5, 5'd6, 5'd0, 16'h0000, 26'h0, 0);
        default: beat(5'd19, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h100, 1);
      endcase
      chk($sformatf("s2_ready%0d", k), in_ready, 1);
      step;
      chk($sformatf("s2_we%0d", k), imem_we, 1);
      chk($sformatf("s2_addr%0d", k), imem_addr, k);
      chk($sformatf("s2_wdata%0d", k), imem_wdata, s2[k]);
    end
    idle_in; step;
    chk("s2_done", done, 1);
    chk("s2_wc", word_count, 4);
    chk("s2_we_off", imem_we, 0);
`ifdef KGP_ENC_CHECKSUM_EN
    cs_exp = s2[0] ^ s2[1] ^ s2[2] ^ s2[3];
    chk("s2_checksum", checksum, cs_exp);
`endif

    start = 1; step; start = 0;
    beat(5'd0, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0, 0); step;
    chk("s3_we0", imem_we, 1);
    chk("s3_addr0", imem_addr, 0);
    beat(5'd25, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 0); step;
    chk("s3_gap_we", imem_we, 0);
    beat(5'd0, 5'd3, 5'd4, 5'd0, 16'h0, 26'h0, 1); step; idle_in;
    chk("s3_we1", imem_we, 1);
    chk("s3_addr1", imem_addr, 1);
    chk("s3_wdata1", imem_wdata, 32'h00640000);
    step;
    chk("s3_ill", err_illegal, 1);
    chk("s3_wc", word_count, 2);
    chk("s3_done", done, 1);

    start = 1; step; start = 0;
    for (int k = 0; k < 4; k++) begin
      beat(5'd0, 5'(k), 5'd0, 5'd0, 16'h0, 26'h0, 0);
      chk($sformatf("s4_ready%0d", k), in_ready, 1);
      step;
      chk($sformatf("s4_addr%0d", k), imem_addr, k);
    end
    beat(5'd0, 5'd9, 5'd0, 5'd0, 16'h0, 26'h0, 0);
    chk("s4_ready_full", in_ready, 0);
    step;
    chk("s4_no5th", imem_we, 0);
    chk("s4_err_full", err_full, 1);
    chk("s4_wc", word_count, 4);
    step; idle_in;
    chk("s4_no5th_b", imem_we, 0);

    start = 1; step; start = 0;
    chk("s5_ign_wc", word_count, 4);
    chk("s5_ign_full", err_full, 1);
    chk("s5_ign_busy", busy, 1);
    rst_n = 0; step;
    chk_zero("s5_rst");
    rst_n = 1;
    start = 1; step; start = 0;
    beat(5'd0, 5'd1, 5'd2, 5'd0, 16'h0, 26'h0, 0); step; idle_in;
    chk("s5_pending_we", imem_we, 1);
    rst_n = 0; step;
    chk_zero("s5_abort");
    rst_n = 1; step;
    chk("s5_idle_busy", busy, 0);
    chk("s5_idle_we", imem_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
